// File: rtl/noc_input_port_if.sv
`default_nettype none
// ============================================================================
// Module  : noc_input_port_if
// Purpose : Bundles the link-side flit handshake and the switch-side
//           request/grant signals of one router input port.
// Ports   : in_data/in_valid/in_last/in_ready - upstream link handshake
//           out_data/out_request/sw_grant     - crossbar request and grant
//           slave modport  : view of the input port itself
//           master modport : view of the link driver plus the switch
// Revision: 1.0 - initial release
// ============================================================================
interface noc_input_port_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_request;
  logic       sw_grant;

  modport slave (
    input  in_data, in_valid, in_last, sw_grant,
    output in_ready, out_data, out_request
  );

  modport master (
    output in_data, in_valid, in_last, sw_grant,
    input  in_ready, out_data, out_request
  );
endinterface
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module  : noc_input_port
// Purpose : Input stage of a mesh router. Buffers {last,data} flits in a
//           DEPTH-entry FIFO, XY-routes each packet's header flit and holds
//           that route until the tail flit is consumed (wormhole switching).
// Ports   : clk, rst         - clock, synchronous active-high reset
//           port_if (slave)  - link handshake in, head flit + 3-bit request
//                              code out (000 L,001 N,010 E,011 S,100 W,111 none)
//           pkt_count, drop_hdr - only with NOC_INPORT_STATS_EN defined:
//                              saturating tail-flit counter and a pulse when a
//                              header routes back toward IN_DIR
// Options : `define NOC_INPORT_STATS_EN to add the statistics outputs.
// Revision: 1.0 - initial release
// ============================================================================
module noc_input_port #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  LOCAL_X = 4'd0,
  parameter logic [3:0]  LOCAL_Y = 4'd0
`ifdef NOC_INPORT_STATS_EN
  ,
  parameter logic [2:0]  IN_DIR  = 3'b111
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  noc_input_port_if.slave         port_if
`ifdef NOC_INPORT_STATS_EN
  ,
  output logic [15:0]             pkt_count,
  output logic [0:0]              drop_hdr
`endif
);

  localparam int unsigned     c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL_CNT = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

  localparam logic [2:0] c_REQ_L    = 3'b000;
  localparam logic [2:0] c_REQ_N    = 3'b001;
  localparam logic [2:0] c_REQ_E    = 3'b010;
  localparam logic [2:0] c_REQ_S    = 3'b011;
  localparam logic [2:0] c_REQ_W    = 3'b100;
  localparam logic [2:0] c_REQ_NONE = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // FIFO storage: bit 8 is the tail marker, bits 7:0 the flit payload.
  logic [8:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_route;
  logic [2:0] w_route_nxt;

  logic [8:0] w_head;
  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_present;

  // Dimension-ordered routing: resolve X first, then Y, else eject locally.
  function automatic logic [2:0] f_xy_route(input logic [7:0] hdr);
    if (hdr[7:4] > LOCAL_X)      return c_REQ_E;
    else if (hdr[7:4] < LOCAL_X) return c_REQ_W;
    else if (hdr[3:0] < LOCAL_Y) return c_REQ_N;
    else if (hdr[3:0] > LOCAL_Y) return c_REQ_S;
    else                         return c_REQ_L;
  endfunction

  assign w_head    = r_mem[r_rd_ptr];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL_CNT);
  assign w_push    = port_if.in_valid && !w_full;
  // A flit is only offered while a route is held and data is buffered, so a
  // grant seen outside that window is ignored.
  assign w_present = (r_state == S_ACTIVE) && !w_empty;
  assign w_pop     = w_present && port_if.sw_grant;

  assign port_if.in_ready    = !w_full;
  assign port_if.out_request = w_present ? r_route : c_REQ_NONE;
  assign port_if.out_data    = w_present ? w_head[7:0] : 8'h00;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {port_if.in_last, port_if.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_route <= c_REQ_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
    end
  end

  // IDLE latches the route of whatever flit sits at the FIFO head (always a
  // header there); ACTIVE holds it until the tail flit is popped, which forces
  // one request-free cycle before the next packet is routed.
  always_comb begin
    w_state_nxt = r_state;
    w_route_nxt = r_route;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_ACTIVE;
          w_route_nxt = f_xy_route(w_head[7:0]);
        end
      end
      S_ACTIVE: begin
        if (w_pop && w_head[8]) begin
          w_state_nxt = S_IDLE;
          w_route_nxt = c_REQ_NONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_route_nxt = c_REQ_NONE;
      end
    endcase
  end

`ifdef NOC_INPORT_STATS_EN
  logic [15:0] r_pkt_count;
  logic        r_drop_hdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= 16'h0000;
      r_drop_hdr  <= 1'b0;
    end else begin
      if (w_pop && w_head[8] && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 16'h0001;
      end
      // Flag a U-turn header; the packet is still forwarded normally.
      r_drop_hdr <= (r_state == S_IDLE) && !w_empty && (IN_DIR != c_REQ_NONE) &&
                    (f_xy_route(w_head[7:0]) == IN_DIR);
    end
  end

  assign pkt_count = r_pkt_count;
  assign drop_hdr  = r_drop_hdr;
`endif

endmodule
`default_nettype wire
